// File: rtl/accel_spi_reader.sv
// rtl/accel_spi_reader.sv - periodic SPI mode-0 reader of one 16-bit accelerometer axis
// Build option: define ACC_OFFSET_BINARY_EN to present samples as offset binary.
module accel_spi_reader #(
  parameter int         CLK_DIV       = 4,
  parameter int         SAMPLE_PERIOD = 400,
  parameter logic [7:0] REG_ADDR      = 8'h0E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  output logic [15:0] acc_out,
  output logic        sample_en,
  output logic        busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]    CMD_READ = 8'h0B;
  localparam logic [31:0]   TX_FRAME = {CMD_READ, REG_ADDR, 16'h0000};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state;
  logic [PW-1:0] per_cnt;
  logic [DW-1:0] div_cnt;
  logic [6:0]    half_cnt;
  logic [31:0]   tx_sr;
  logic [15:0]   rx_sr;

  logic          in_frame;
  logic          half_tick;
  logic [6:0]    half_next;
  logic          sclk_rise;
  logic          sclk_fall;
  logic          frame_start;
  logic [15:0]   raw;
  logic [15:0]   sample_conv;

  // Half-period events are numbered 1..66 from CS fall: odd 1..63 raise SCLK,
  // even 2..64 lower it, 65 is dead time in HOLD and 66 releases CS.
  always_comb begin
    in_frame    = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    half_tick   = in_frame && (div_cnt == DIV_LAST);
    half_next   = half_cnt + 7'd1;
    sclk_rise   = half_tick && half_next[0] && (half_next <= 7'd63);
    sclk_fall   = half_tick && !half_next[0] && (half_next <= 7'd64);
    frame_start = (state == ST_IDLE) && run && (per_cnt == '0);
    // Only the last two received bytes survive in rx_sr: low byte then high byte.
    raw         = {rx_sr[7:0], rx_sr[15:8]};
  end

`ifdef ACC_OFFSET_BINARY_EN
  assign sample_conv = raw ^ 16'h8000;
`else
  assign sample_conv = raw;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt <= '0;
    end else if (!run) begin
      per_cnt <= '0;
    end else if (per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      half_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      spi_sclk  <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      acc_out   <= '0;
      sample_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sample_en <= 1'b0;
      if (state == ST_IDLE) begin
        if (frame_start) begin
          state    <= ST_SETUP;
          div_cnt  <= '0;
          half_cnt <= '0;
          tx_sr    <= TX_FRAME;
          spi_mosi <= TX_FRAME[31];
          spi_cs_n <= 1'b0;
          busy     <= 1'b1;
        end
      end else if (in_frame) begin
        if (half_tick) begin
          div_cnt  <= '0;
          half_cnt <= half_next;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (sclk_rise) begin
          spi_sclk <= 1'b1;
          rx_sr    <= {rx_sr[14:0], spi_miso};
        end
        // Zeros shift in behind the frame, so MOSI returns low after the last fall.
        if (sclk_fall) begin
          spi_sclk <= 1'b0;
          spi_mosi <= tx_sr[30];
          tx_sr    <= {tx_sr[30:0], 1'b0};
        end
        if (half_tick && (half_next == 7'd1)) begin
          state <= ST_SHIFT;
        end
        if (half_tick && (half_next == 7'd64)) begin
          state <= ST_HOLD;
        end
        if (half_tick && (half_next == 7'd66)) begin
          state    <= ST_DONE;
          spi_cs_n <= 1'b1;
        end
      end else if (state == ST_DONE) begin
        acc_out   <= sample_conv;
        sample_en <= 1'b1;
        busy      <= 1'b0;
        state     <= ST_IDLE;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

endmodule
